// File: rtl/countdown_timer_if.sv
// Load channel of the countdown timer: start value, prescale and mode are
// offered together by firmware and captured on a valid/ready handshake.
interface countdown_timer_if #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
);
  logic                  load_valid;
  logic                  load_ready;
  logic [WIDTH-1:0]      load_value;
  logic [PRESCALE_W-1:0] load_prescale;
  logic                  load_periodic;

  modport master (
    output load_valid,
    output load_value,
    output load_prescale,
    output load_periodic,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_value,
    input  load_prescale,
    input  load_periodic,
    output load_ready
  );
endinterface

// File: rtl/countdown_timer.sv
// Programmable down-counting timer with prescaler, one-shot/periodic reload,
// sticky expiry irq and overrun flag. Loads are refused while counting.
module countdown_timer #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  countdown_timer_if.slave ld,
  input  logic             start,
  input  logic             stop,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             irq,
  output logic             overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t                state, state_nxt;
  logic [WIDTH-1:0]      count_q;
  logic [WIDTH-1:0]      reload_q;
  logic [PRESCALE_W-1:0] p_q;
  logic [PRESCALE_W-1:0] psc_q;
  logic                  periodic_q;
  logic                  load_fire;
  logic                  tick;
  logic                  expiry;

  assign ld.load_ready = (state != S_RUN);
  assign count         = count_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode plus tick/expiry strobes; stop suppresses the tick so
  // a stop on the expiry edge pauses instead of expiring.
  always_comb begin
    state_nxt = state;
    load_fire = ld.load_valid && (state != S_RUN);
    tick      = (state == S_RUN) && !stop && (psc_q == p_q);
    expiry    = tick && (count_q == ONE);
    case (state)
      S_IDLE: begin
        if (load_fire) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (load_fire)                          state_nxt = S_ARMED;
        else if (start && !stop && count_q != '0) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (stop)                        state_nxt = S_ARMED;
        else if (expiry && !periodic_q)  state_nxt = S_DONE;
      end
      S_DONE: begin
        if (load_fire) state_nxt = S_ARMED;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Count, prescaler, configuration and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= '0;
      reload_q   <= '0;
      p_q        <= '0;
      psc_q      <= '0;
      periodic_q <= 1'b0;
      running    <= 1'b0;
      irq        <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      running <= (state_nxt == S_RUN);
      if (load_fire) begin
        count_q    <= ld.load_value;
        reload_q   <= ld.load_value;
        p_q        <= ld.load_prescale;
        periodic_q <= ld.load_periodic;
        psc_q      <= '0;
      end else if (state == S_RUN) begin
        if (stop || tick) psc_q <= '0;
        else              psc_q <= psc_q + 1'b1;
        if (tick) begin
          if (count_q > ONE)   count_q <= count_q - ONE;
          else if (periodic_q) count_q <= reload_q;
          else                 count_q <= '0;
        end
      end else if (state == S_ARMED) begin
        psc_q <= '0;
      end
      // An ack on the expiry edge loses to the new expiry; overrun only
      // records expiries that nobody has acknowledged.
      overrun <= (overrun && !irq_ack) || (expiry && irq && !irq_ack);
      irq     <= expiry || (irq && !irq_ack);
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer: directed scenarios followed by random
// traffic, compared cycle by cycle against an arithmetic reference model.
module tb_countdown_timer;
  localparam int WIDTH      = 16;
  localparam int PRESCALE_W = 8;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;
  localparam int M_DONE  = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             irq_ack = 1'b0;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             irq;
  logic             overrun;

  countdown_timer_if #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) ld ();

  countdown_timer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld      (ld),
    .start   (start),
    .stop    (stop),
    .irq_ack (irq_ack),
    .count   (count),
    .running (running),
    .irq     (irq),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] count;
    logic             running;
    logic             irq;
    logic             overrun;
    logic             ready;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: counting is expressed as cycles spent running since the
  // last resume, divided into ticks of P+1 cycles.
  int          m_state = M_IDLE;
  int unsigned m_count = 0, m_reload = 0, m_p = 0, n = 0, cb = 0;
  bit          m_per = 0, m_irq = 0, m_ovr = 0;

  task automatic model_step();
    bit          exp_ev = 0;
    bit          ack = irq_ack;
    int unsigned t, k;
    if (!rst_n) begin
      m_state = M_IDLE; m_count = 0; m_reload = 0; m_p = 0; m_per = 0;
      m_irq = 0; m_ovr = 0; n = 0; cb = 0;
      return;
    end
    if (ld.load_valid && m_state != M_RUN) begin
      m_count  = ld.load_value;
      m_reload = ld.load_value;
      m_p      = ld.load_prescale;
      m_per    = ld.load_periodic;
      m_state  = M_ARMED;
    end else if (m_state == M_ARMED) begin
      if (start && !stop && m_count != 0) begin
        m_state = M_RUN; n = 0; cb = m_count;
      end
    end else if (m_state == M_RUN) begin
      if (stop) m_state = M_ARMED;
      else begin
        n++;
        if (n % (m_p + 1) == 0) begin
          t = n / (m_p + 1);
          if (!m_per) begin
            m_count = cb - t;
            if (m_count == 0) begin exp_ev = 1; m_state = M_DONE; end
          end else if (t < cb) begin
            m_count = cb - t;
          end else begin
            k = t - cb;
            m_count = m_reload - (k % m_reload);
            exp_ev = (k % m_reload == 0);
          end
        end
      end
    end
    m_ovr = (m_ovr && !ack) || (exp_ev && m_irq && !ack);
    m_irq = exp_ev || (m_irq && !ack);
  endtask

  // One clock: predict, let the edge happen, queue the prediction.
  task automatic cyc();
    obs_t o;
    model_step();
    o.count   = WIDTH'(m_count);
    o.running = (m_state == M_RUN);
    o.irq     = m_irq;
    o.overrun = m_ovr;
    o.ready   = (m_state != M_RUN);
    @(posedge clk);
    exp_q.push_back(o);
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    repeat (k) cyc();
  endtask

  task automatic do_load(input int v, input int p, input bit per);
    ld.load_valid    = 1'b1;
    ld.load_value    = WIDTH'(v);
    ld.load_prescale = PRESCALE_W'(p);
    ld.load_periodic = per;
    cyc();
    ld.load_valid    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
  endtask

  // Monitor: compare every presented observation against the queue head.
  always @(negedge clk) begin
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if ({count, running, irq, overrun, ld.load_ready} !== e) begin
        fails++;
        $display("FAIL obs t=%0t: got count=%0d run=%0b irq=%0b ovr=%0b rdy=%0b, want count=%0d run=%0b irq=%0b ovr=%0b rdy=%0b",
                 $time, count, running, irq, overrun, ld.load_ready,
                 e.count, e.running, e.irq, e.overrun, e.ready);
      end
    end
  end

  initial begin
    ld.load_valid    = 1'b0;
    ld.load_value    = '0;
    ld.load_prescale = '0;
    ld.load_periodic = 1'b0;

    // Reset from power-up.
    rst_n = 1'b0; idle(2); rst_n = 1'b1; idle(1);

    // One-shot V=5 P=0, later start ignored in DONE, then ack.
    do_load(5, 0, 1'b0); do_start(); idle(6);
    do_start(); idle(2); do_ack(); idle(1);

    // Prescale V=3 P=2.
    do_load(3, 2, 1'b0); do_start(); idle(10); do_ack();

    // Periodic V=2 with overrun, then ack.
    do_load(2, 0, 1'b1); do_start(); idle(4); do_ack(); idle(2);

    // Reset mid-RUN with irq set.
    idle(1); rst_n = 1'b0; cyc(); rst_n = 1'b1; idle(2);

    // Stop/resume with a refused load during RUN.
    do_load(5, 0, 1'b0); do_start();
    ld.load_valid = 1'b1; ld.load_value = WIDTH'(9); ld.load_prescale = '0;
    cyc(); cyc(); ld.load_valid = 1'b0;
    stop = 1'b1; cyc(); stop = 1'b0; idle(2);
    do_start(); idle(6);

    // Expiry coinciding with irq_ack while irq already set.
    do_load(2, 0, 1'b0); do_start(); cyc(); do_ack(); idle(2);

    // start and stop together in RUN, then in ARMED.
    do_load(4, 0, 1'b0); do_start(); cyc();
    start = 1'b1; stop = 1'b1; cyc(); cyc(); start = 1'b0; stop = 1'b0;
    idle(2); do_start(); idle(5); do_ack();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst_n            = ($urandom_range(0, 199) != 0);
      ld.load_valid    = ($urandom_range(0, 9) == 0);
      ld.load_value    = WIDTH'($urandom_range(0, 6));
      ld.load_prescale = PRESCALE_W'($urandom_range(0, 3));
      ld.load_periodic = $urandom_range(0, 1) == 1;
      start            = ($urandom_range(0, 3) == 0);
      stop             = ($urandom_range(0, 15) == 0);
      irq_ack          = ($urandom_range(0, 9) == 0);
      cyc();
    end
    rst_n = 1'b1; ld.load_valid = 1'b0; start = 1'b0; stop = 1'b0; irq_ack = 1'b0;

    @(negedge clk);
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d observations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
